// File: rtl/apb_controller_if.sv
// AHB-side and APB-side bus signals of the AHB-to-APB bridge core (apb_controller).
// Handshake: the bridge samples a transfer on a rising Hclk edge only when Hreadyout=1
// and the master presents Hreadyin=1 with Htrans NONSEQ/SEQ; while Hreadyout=0 the master
// holds its address phase (and write data) unchanged and nothing new is sampled.
interface apb_controller_if;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        Pwrite;
  logic        Penable;
  logic [2:0]  Pselx;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Hreadyout;
  logic [31:0] Hrdata;
  logic [1:0]  Hresp;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
    output Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout, Hrdata, Hresp
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
    input  Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout, Hrdata, Hresp
  );
endinterface

// File: rtl/apb_controller.sv
// AHB-to-APB bridge core: decodes three 64 MB APB slots and runs SETUP/ENABLE per transfer.
// Optional AHB_ERR_RESP_EN: out-of-window transfers get a two-cycle ERROR response (ERR1/ERR2).
module apb_controller #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned SLOT_BITS = 26
) (
  input  logic            Hclk,
  input  logic            Hresetn,
  apb_controller_if.slave bus,
  output logic [2:0]      o_dbg_state
);

`ifdef AHB_ERR_RESP_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WWAIT  = 3'd1,
    S_SETUP  = 3'd2,
    S_ENABLE = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WWAIT  = 3'd1,
    S_SETUP  = 3'd2,
    S_ENABLE = 3'd3
  } state_t;
`endif

  localparam logic [32:0] WIN_SIZE = 33'd3 << SLOT_BITS;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_haddr;
  logic        r_hwrite;
  logic [2:0]  r_pselx;
  logic        r_penable;
  logic        r_pwrite;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;

  logic [2:0]  w_pselx_nxt;
  logic        w_penable_nxt;
  logic        w_pwrite_nxt;
  logic [31:0] w_paddr_nxt;
  logic [31:0] w_pwdata_nxt;
  logic        w_latch;
  logic [31:0] w_off;
  logic        w_in_win;
  logic        w_xfer;
  logic        w_valid;
  logic        w_hreadyout;
  logic [1:0]  w_hresp;

  function automatic logic [2:0] slot_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    slot_sel = 3'b001;
      2'd1:    slot_sel = 3'b010;
      2'd2:    slot_sel = 3'b100;
      default: slot_sel = 3'b000;
    endcase
  endfunction

  // Window check done on the offset so the upper bound cannot wrap past 2^32.
  assign w_off    = bus.Haddr - BASE_ADDR;
  assign w_in_win = (bus.Haddr >= BASE_ADDR) && ({1'b0, w_off} < WIN_SIZE);
  assign w_xfer   = bus.Hreadyin && ((bus.Htrans == 2'b10) || (bus.Htrans == 2'b11));
  assign w_valid  = w_xfer && w_in_win;

`ifdef AHB_ERR_RESP_EN
  assign w_hreadyout = (r_state == S_IDLE) || (r_state == S_ENABLE) || (r_state == S_ERR2);
  assign w_hresp     = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
`else
  assign w_hreadyout = (r_state == S_IDLE) || (r_state == S_ENABLE);
  assign w_hresp     = 2'b00;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_pselx_nxt   = r_pselx;
    w_penable_nxt = r_penable;
    w_pwrite_nxt  = r_pwrite;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_latch       = 1'b0;
    case (r_state)
      S_WWAIT: begin
        // Write data phase ends here; APB outputs come from the latched address phase.
        w_state_nxt   = S_SETUP;
        w_pselx_nxt   = slot_sel(r_haddr[SLOT_BITS+1 -: 2]);
        w_paddr_nxt   = r_haddr;
        w_pwrite_nxt  = r_hwrite;
        w_pwdata_nxt  = bus.Hwdata;
        w_penable_nxt = 1'b0;
      end
      S_SETUP: begin
        w_state_nxt   = S_ENABLE;
        w_penable_nxt = 1'b1;
      end
`ifdef AHB_ERR_RESP_EN
      S_ERR1: begin
        w_state_nxt = S_ERR2;
      end
`endif
      default: begin
        // Sampling states (IDLE, ENABLE, ERR2); reads skip WWAIT and go straight to SETUP.
        w_latch       = w_valid;
        w_penable_nxt = 1'b0;
        if (w_valid && !bus.Hwrite) begin
          w_state_nxt  = S_SETUP;
          w_pselx_nxt  = slot_sel(bus.Haddr[SLOT_BITS+1 -: 2]);
          w_paddr_nxt  = bus.Haddr;
          w_pwrite_nxt = 1'b0;
        end else if (w_valid) begin
          w_state_nxt = S_WWAIT;
`ifdef AHB_ERR_RESP_EN
        end else if (w_xfer) begin
          w_state_nxt = S_ERR1;
          w_pselx_nxt = 3'b000;
`endif
        end else begin
          w_state_nxt = S_IDLE;
          w_pselx_nxt = 3'b000;
        end
      end
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state   <= S_IDLE;
      r_haddr   <= 32'h0;
      r_hwrite  <= 1'b0;
      r_pselx   <= 3'b000;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= 32'h0;
      r_pwdata  <= 32'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_pselx   <= w_pselx_nxt;
      r_penable <= w_penable_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
      if (w_latch) begin
        r_haddr  <= bus.Haddr;
        r_hwrite <= bus.Hwrite;
      end
    end
  end

  assign bus.Pselx     = r_pselx;
  assign bus.Penable   = r_penable;
  assign bus.Pwrite    = r_pwrite;
  assign bus.Paddr     = r_paddr;
  assign bus.Pwdata    = r_pwdata;
  assign bus.Hreadyout = w_hreadyout;
  assign bus.Hresp     = w_hresp;
  assign bus.Hrdata    = ((r_state == S_ENABLE) && !r_pwrite) ? bus.Prdata : 32'h0;
  assign o_dbg_state   = r_state;

endmodule
